ddp_queue_sched: RTL

//  Round-robin packet scheduler for the DDP transmit path. It sits between the per-queue
//  256-bit payload FIFOs (emptyArray/dataOut) and the DDP assembler. It picks one
//  non-empty queue and keeps the grant on that queue for a whole packet, pops its beats

---
 rtl/ddp_queue_sched_if.sv | 42 ++++
 rtl/ddp_queue_sched.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ddp_queue_sched_if.sv
// Handshake bundle between the payload queues, the packet scheduler and the DDP assembler.
// The per-queue weights vector exists only when DDP_SCHED_WEIGHT_EN is defined.
interface ddp_queue_sched_if #(
    parameter int unsigned NQ  = 4,
    parameter int unsigned QW  = 2,
    parameter int unsigned BCW = 4
);
    logic [NQ-1:0]   emptyArray;
    logic [NQ-1:0]   lastIn;
    logic            ready;
    logic            ddpPktFull;
`ifdef DDP_SCHED_WEIGHT_EN
    logic [4*NQ-1:0] weights;
`endif
    logic            dataPop;
    logic [QW-1:0]   popQN;
    logic            grantValid;
    logic            pktDone;
    logic [QW-1:0]   pktDoneQN;
    logic [BCW-1:0]  pktBeats;
    logic            errOverrun;

`ifdef DDP_SCHED_WEIGHT_EN
    modport master (
        output emptyArray, lastIn, ready, ddpPktFull, weights,
        input  dataPop, popQN, grantValid, pktDone, pktDoneQN, pktBeats, errOverrun
    );
    modport slave (
        input  emptyArray, lastIn, ready, ddpPktFull, weights,
        output dataPop, popQN, grantValid, pktDone, pktDoneQN, pktBeats, errOverrun
    );
`else
    modport master (
        output emptyArray, lastIn, ready, ddpPktFull,
        input  dataPop, popQN, grantValid, pktDone, pktDoneQN, pktBeats, errOverrun
    );
    modport slave (
        input  emptyArray, lastIn, ready, ddpPktFull,
        output dataPop, popQN, grantValid, pktDone, pktDoneQN, pktBeats, errOverrun
    );
`endif
endinterface

// File: rtl/ddp_queue_sched.sv
// Round-robin packet scheduler: holds a grant on one payload queue for a whole packet.
// Define DDP_SCHED_WEIGHT_EN to let a queue keep its turn for up to weights[i] packets.
module ddp_queue_sched #(
    parameter int unsigned NQ        = 4,
    parameter int unsigned QW        = 2,
    parameter int unsigned MAX_BEATS = 8,
    parameter int unsigned BCW       = 4
) (
    input  logic             clock,
    input  logic             reset,
    ddp_queue_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [QW-1:0]  rrPtr;
    logic [BCW-1:0] beatCnt;
    logic [QW-1:0]  popQN;
    logic           grantValid;
    logic           pktDone;
    logic [QW-1:0]  pktDoneQN;
    logic [BCW-1:0] pktBeats;
    logic           errOverrun;

    logic           popNow;
    logic           lastHead;
    logic           found;
    logic [QW-1:0]  searchQ;
    int unsigned    cand;
    logic           anyAvail;
    logic [QW-1:0]  pickQ;

    assign lastHead = bus.lastIn[popQN];
    assign popNow   = (state == XFER) & grantValid & bus.ready & ~bus.emptyArray[popQN];

    // First non-empty queue after rrPtr, wrapping below NQ so no out-of-range index appears
    always_comb begin
        found   = 1'b0;
        searchQ = '0;
        cand    = 0;
        for (int unsigned k = 1; k <= NQ; k++) begin
            cand = 32'(rrPtr) + k;
            if (cand >= NQ) cand = cand - NQ;
            if (!found && !bus.emptyArray[cand[QW-1:0]]) begin
                found   = 1'b1;
                searchQ = QW'(cand);
            end
        end
    end

`ifdef DDP_SCHED_WEIGHT_EN
    logic [3:0] pktCnt [NQ];
    logic       turnOwned;
    logic       holdGrant;
    logic       holdOk;
    logic [3:0] rawWgt;
    logic [3:0] curWgt;

    // The queue holding the turn is re-picked while it has packets left and data waiting
    assign holdOk   = turnOwned & (pktCnt[rrPtr] != 4'd0) & ~bus.emptyArray[rrPtr];
    assign anyAvail = holdOk | found;
    assign pickQ    = holdOk ? rrPtr : searchQ;
    assign rawWgt   = bus.weights[{popQN, 2'b00} +: 4];
    assign curWgt   = (rawWgt == 4'd0) ? 4'd1 : rawWgt;
`else
    assign anyAvail = found;
    assign pickQ    = searchQ;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rrPtr      <= QW'(NQ - 1);
            beatCnt    <= '0;
            popQN      <= '0;
            grantValid <= 1'b0;
            pktDone    <= 1'b0;
            pktDoneQN  <= '0;
            pktBeats   <= '0;
            errOverrun <= 1'b0;
`ifdef DDP_SCHED_WEIGHT_EN
            turnOwned  <= 1'b0;
            holdGrant  <= 1'b0;
            for (int unsigned i = 0; i < NQ; i++) pktCnt[i] <= 4'd0;
`endif
        end else begin
            pktDone    <= 1'b0;
            errOverrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.ddpPktFull && anyAvail) begin
                        popQN      <= pickQ;
                        grantValid <= 1'b1;
                        state      <= XFER;
`ifdef DDP_SCHED_WEIGHT_EN
                        holdGrant  <= holdOk;
`endif
                    end
                end
                XFER: begin
                    if (popNow) begin
                        beatCnt <= beatCnt + BCW'(1);
                        if (lastHead || (beatCnt == BCW'(MAX_BEATS - 1))) begin
                            state      <= DONE;
                            pktDone    <= 1'b1;
                            pktDoneQN  <= popQN;
                            pktBeats   <= beatCnt + BCW'(1);
                            errOverrun <= ~lastHead;
                        end
                    end
                end
                DONE: begin
                    rrPtr      <= popQN;
                    beatCnt    <= '0;
                    grantValid <= 1'b0;
                    state      <= IDLE;
`ifdef DDP_SCHED_WEIGHT_EN
                    // A fresh turn reloads the budget, counting the packet just sent
                    if (holdGrant) pktCnt[popQN] <= pktCnt[popQN] - 4'd1;
                    else           pktCnt[popQN] <= curWgt - 4'd1;
                    turnOwned  <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dataPop    = popNow;
    assign bus.popQN      = popQN;
    assign bus.grantValid = grantValid;
    assign bus.pktDone    = pktDone;
    assign bus.pktDoneQN  = pktDoneQN;
    assign bus.pktBeats   = pktBeats;
    assign bus.errOverrun = errOverrun;
endmodule
